// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
//   md_op_e      : operation codes driven by the decode/E pipeline
//   state_e      : IDLE/RUN view of the latency counter
//   *_CYCLES_DEF : default busy durations
//   is_mul_op / is_div_op : op classification helpers
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic is_mul_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Bundle between the E stage and the multiply/divide unit.
//   master (pipeline) drives : md_start, md_op, md_a, md_b
//   slave  (e_mdu)    drives : md_busy, md_stall_src, md_rdata, hi_q, lo_q
interface e_mdu_if;
  import e_mdu_pkg::*;

  logic        md_start;
  md_op_e      md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_busy;
  logic        md_stall_src;
  logic [31:0] md_rdata;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  modport master (
    output md_start, md_op, md_a, md_b,
    input  md_busy, md_stall_src, md_rdata, hi_q, lo_q
  );

  modport slave (
    input  md_start, md_op, md_a, md_b,
    output md_busy, md_stall_src, md_rdata, hi_q, lo_q
  );
endinterface

// File: rtl/e_mdu_arith.sv
// Combinational arithmetic core of the MDU.
//   op_i        : operation; only MULT/MULTU/DIV/DIVU produce a result
//   a_i, b_i    : rs / rt operands
//   hi_o, lo_o  : {HI,LO} result (product, or remainder/quotient)
//   div_zero_o  : divide op with b_i == 0 (result must not be committed)
module mdu_arith
  import e_mdu_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    prod_u = {32'd0, a_i} * {32'd0, b_i};
  end

  // Signed divide is done on magnitudes and the signs fixed afterwards, so
  // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 instead of
  // overflowing. A zero divisor is replaced by 1 to keep the divider defined;
  // div_zero_o suppresses the commit anyway.
  always_comb begin
    neg_a = (op_i == MD_DIV) && a_i[31];
    neg_b = (op_i == MD_DIV) && b_i[31];
    dvd   = neg_a ? (~a_i + 32'd1) : a_i;
    dvs   = neg_b ? (~b_i + 32'd1) : b_i;
    if (b_i == '0) dvs = 32'd1;
    quo   = dvd / dvs;
    rem   = dvd % dvs;
    if (neg_a ^ neg_b) quo = ~quo + 32'd1;
    if (neg_a)         rem = ~rem + 32'd1;
  end

  always_comb begin
    hi_o       = '0;
    lo_o       = '0;
    div_zero_o = 1'b0;
    unique case (op_i)
      MD_MULT:  {hi_o, lo_o} = prod_s;
      MD_MULTU: {hi_o, lo_o} = prod_u;
      MD_DIV, MD_DIVU: begin
        hi_o       = rem;
        lo_o       = quo;
        div_zero_o = (b_i == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU with a
// fixed latency, handles MTHI/MTLO writes and MFHI/MFLO reads.
//   clk, reset : clock, synchronous active-high reset
//   md (slave) : md_start/md_op/md_a/md_b in; md_busy, md_stall_src,
//                md_rdata, hi_q, lo_q out
// The result is computed at issue and parked in pend_*; HI/LO only change
// when the counter expires, so MFHI/MFLO never see an in-flight result.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     reset,
  e_mdu_if.slave   md
);

  logic [3:0]  cnt_q,     cnt_d;
  logic [31:0] hi_q,      hi_d;
  logic [31:0] lo_q,      lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  state_e      state;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero;

  mdu_arith u_arith (
    .op_i       (md.md_op),
    .a_i        (md.md_a),
    .b_i        (md.md_b),
    .hi_o       (res_hi),
    .lo_o       (res_lo),
    .div_zero_o (div_zero)
  );

  // The counter is the state register; IDLE/RUN is a decode of it.
  assign state = (cnt_q == '0) ? S_IDLE : S_RUN;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    unique case (state)
      S_IDLE: begin
        if (md.md_start && (is_mul_op(md.md_op) || is_div_op(md.md_op))) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_wr_d = ~div_zero;
          cnt_d     = is_mul_op(md.md_op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        end else if (md.md_op == MD_MTHI) begin
          hi_d = md.md_a;
        end else if (md.md_op == MD_MTLO) begin
          lo_d = md.md_a;
        end
      end
      S_RUN: begin
        // A new md_start here is a protocol violation and is dropped.
        if (cnt_q == 4'd1) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    md.md_busy      = (state == S_RUN);
    md.md_stall_src = md.md_start | md.md_busy;
    md.hi_q         = hi_q;
    md.lo_q         = lo_q;
    md.md_rdata     = '0;
    if (md.md_op == MD_MFHI)      md.md_rdata = hi_q;
    else if (md.md_op == MD_MFLO) md.md_rdata = lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu. Each driven cycle pushes the expected outputs
// for that cycle; a negedge monitor pops and compares. Result values are
// hand-computed constants handed to the issue calls.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic clk;
  logic reset;

  e_mdu_if md ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        busy;
    logic        stall;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Expected-state tracking: latency and commit timing only.
  int unsigned e_cnt = 0;
  logic [31:0] e_hi = '0, e_lo = '0, e_ph = '0, e_pl = '0;
  logic        e_pw = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".busy"},  {31'd0, md.md_busy},      {31'd0, e.busy});
      chk({e.name, ".stall"}, {31'd0, md.md_stall_src}, {31'd0, e.stall});
      chk({e.name, ".rdata"}, md.md_rdata, e.rdata);
      chk({e.name, ".hi"},    md.hi_q, e.hi);
      chk({e.name, ".lo"},    md.lo_q, e.lo);
      // Start while busy must never be issued.
      chk({e.name, ".start_while_busy"}, {31'd0, md.md_start & md.md_busy}, 32'd0);
    end
  end

  task automatic cyc(input string nm, input logic rst, input logic start, input md_op_e op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] rh, input logic [31:0] rl, input logic wr);
    exp_t e;
    reset       = rst;
    md.md_start = start;
    md.md_op    = op;
    md.md_a     = a;
    md.md_b     = b;
    e.name  = nm;
    e.busy  = (e_cnt != 0);
    e.stall = start || (e_cnt != 0);
    e.rdata = (op == MD_MFHI) ? e_hi : (op == MD_MFLO) ? e_lo : 32'd0;
    e.hi    = e_hi;
    e.lo    = e_lo;
    sb.push_back(e);
    if (rst) begin
      e_cnt = 0; e_hi = '0; e_lo = '0;
    end else if (e_cnt == 0) begin
      if (start && (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU)) begin
        e_cnt = (op == MD_MULT || op == MD_MULTU) ? 5 : 10;
        e_ph = rh; e_pl = rl; e_pw = wr;
      end else if (op == MD_MTHI) e_hi = a;
      else if (op == MD_MTLO) e_lo = a;
    end else if (e_cnt == 1) begin
      if (e_pw) begin e_hi = e_ph; e_lo = e_pl; end
      e_cnt = 0;
    end else begin
      e_cnt--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input md_op_e op, input int n);
    for (int i = 0; i < n; i++) cyc(nm, 1'b0, 1'b0, op, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic issue(input string nm, input md_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] rh,
                       input logic [31:0] rl, input logic wr);
    cyc(nm, 1'b0, 1'b1, op, a, b, rh, rl, wr);
  endtask

  initial begin
    int w;
    reset       = 1'b1;
    md.md_start = 1'b0;
    md.md_op    = MD_NONE;
    md.md_a     = '0;
    md.md_b     = '0;
    repeat (2) @(posedge clk);
    #1;

    idle("rst_mfhi", MD_MFHI, 1);
    idle("rst_mflo", MD_MFLO, 1);

    // -3 * 5 = -15
    issue("mult", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);
    idle("mult_wait", MD_MFLO, 7);

    issue("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    idle("multu_wait", MD_NONE, 5);
    idle("multu_mfhi", MD_MFHI, 1);

    // -7 / 2 -> q=-3, r=-1
    issue("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    idle("div_wait", MD_MFLO, 11);

    issue("divu", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b1);
    idle("divu_wait", MD_MFHI, 11);

    cyc("mthi", 1'b0, 1'b0, MD_MTHI, 32'h1234_5678, '0, '0, '0, 1'b0);
    idle("mthi_mfhi", MD_MFHI, 1);
    cyc("mtlo", 1'b0, 1'b0, MD_MTLO, 32'hCAFE_F00D, '0, '0, '0, 1'b0);
    idle("mtlo_mflo", MD_MFLO, 1);

    // Divide by zero: full latency, HI/LO untouched.
    issue("divu0", MD_DIVU, 32'd7, 32'd0, '0, '0, 1'b0);
    idle("divu0_wait", MD_MFHI, 11);

    issue("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1);
    idle("div_ovf_wait", MD_MFLO, 11);

    // md_start with a non-MD op: no busy, stall_src only for that cycle.
    cyc("start_nonmd", 1'b0, 1'b1, MD_MFLO, 32'h1111_1111, '0, '0, '0, 1'b0);
    idle("start_nonmd_after", MD_NONE, 1);

    // Reset in busy cycle 3 of a DIV; the abandoned result must never land.
    issue("div_rst", MD_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    idle("div_rst_busy", MD_NONE, 2);
    cyc("div_rst_reset", 1'b1, 1'b0, MD_NONE, '0, '0, '0, '0, 1'b0);
    idle("div_rst_after", MD_MFLO, 12);

    w = 0;
    while (sb.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
